// File: rtl/m16_uart_pkg.sv
// rtl/m16_uart_pkg.sv - shared FSM encodings and 8N1 frame constants for the M16 polling UART
package m16_uart_pkg;

  localparam int         DATA_BITS  = 8;
  localparam int         STOP_BITS  = 1;
  localparam int         FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
  localparam logic [7:0] FILL_BYTE  = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_RX_WAIT,
    S_RX_BYTE,
    S_FILL,
    S_DONE
  } poll_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/m16_uart_rx_byte.sv
// rtl/m16_uart_rx_byte.sv - 8N1 byte receiver: synchronizer, start-bit check, bit timer, shifter
module m16_uart_rx_byte
  import m16_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 17
) (
  input  logic       clk80MHz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err,
  output logic       start_seen
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_e     state, state_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          fall, tick_half, tick_bit;

  assign fall      = rx_prev & ~rx_sync;
  assign tick_half = (timer == TW'(HALF - 1));
  assign tick_bit  = (timer == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_n;
  end

  // A start bit that reads high at mid-bit is a glitch: drop back to hunting.
  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:  if (enable && fall) state_n = RX_START;
      RX_START: if (tick_half) state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_bit && bit_idx == 3'(DATA_BITS - 1)) state_n = RX_STOP;
      RX_STOP:  if (tick_bit) state_n = RX_IDLE;
      default:  state_n = RX_IDLE;
    endcase
    if (!enable) state_n = RX_IDLE;
  end

  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      stop_err   <= 1'b0;
      start_seen <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      start_seen <= 1'b0;
      case (state)
        RX_START: begin
          if (tick_half) begin
            timer      <= '0;
            start_seen <= enable & ~rx_sync;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick_bit) begin
            timer   <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_bit) begin
            timer      <= '0;
            byte_valid <= enable;
            byte_data  <= shift;
            stop_err   <= ~rx_sync;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          timer   <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/m16_uart_poll.sv
// rtl/m16_uart_poll.sv - RS-485 poll channel: send command, turn bus, collect PKT_LEN reply bytes
// Optional: M16_RX_FILL_EN pads a timed-out reply with FILL_BYTE writes up to PKT_LEN.
module m16_uart_poll
  import m16_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 17,
  parameter int PKT_LEN      = 18,
  parameter int ADDR_W       = 5,
  parameter int TURN_CLKS    = 34,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic              clk80MHz,
  input  logic              rst_n,
  input  logic              poll_start,
  input  logic [7:0]        req_byte,
  input  logic              UART_RX,
  output logic              UART_TX,
  output logic              UART_dTX,
  output logic              UART_dRX,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done,
  output logic              pkt_ok,
  output logic              timeout,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam int BC_W  = ADDR_W + 1;

  poll_state_e           state, state_n;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [3:0]            tx_bits;
  logic [CNT_W-1:0]      cnt;
  logic [BC_W-1:0]       byte_cnt;
  logic                  finished;
  logic                  accept, tx_bit_end, turn_end, idle_exp, last_byte, rx_en;
  logic                  byte_valid, stop_err, start_seen;
  logic [7:0]            byte_data;

  m16_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk80MHz  (clk80MHz),
    .rst_n     (rst_n),
    .enable    (rx_en),
    .rx        (UART_RX),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .stop_err  (stop_err),
    .start_seen(start_seen)
  );

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign accept     = poll_start & ~busy;
  assign UART_dTX   = (state == S_TX);
  assign UART_dRX   = (state == S_TX) || (state == S_TURN);
  assign UART_TX    = (state == S_TX) ? tx_shift[0] : 1'b1;
  assign rx_en      = (state == S_RX_WAIT) || (state == S_RX_BYTE);
  assign pkt_ok     = finished & ~timeout & ~frame_err;
  assign tx_bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign turn_end   = (cnt == CNT_W'(TURN_CLKS - 1));
  assign idle_exp   = (cnt >= CNT_W'(TIMEOUT_CLKS - 1));
  assign last_byte  = (byte_cnt == BC_W'(PKT_LEN - 1));

  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (accept) state_n = S_TX;
      S_TX:      if (tx_bit_end && tx_bits == 4'(FRAME_BITS - 1)) state_n = S_TURN;
      S_TURN:    if (turn_end) state_n = S_RX_WAIT;
      S_RX_WAIT: begin
        if (start_seen) begin
          state_n = S_RX_BYTE;
        end else if (idle_exp) begin
`ifdef M16_RX_FILL_EN
          state_n = S_FILL;
`else
          state_n = S_DONE;
`endif
        end
      end
      S_RX_BYTE: if (byte_valid) state_n = last_byte ? S_DONE : S_RX_WAIT;
      S_FILL:    if (last_byte) state_n = S_DONE;
      S_DONE:    state_n = accept ? S_TX : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // One shared timer: bit time in TX, guard in TURN, saturating idle count in RX_WAIT.
  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift  <= '1;
      tx_bits   <= '0;
      cnt       <= '0;
      byte_cnt  <= '0;
      finished  <= 1'b0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        tx_shift  <= {1'b1, req_byte, 1'b0};
        tx_bits   <= '0;
        cnt       <= '0;
        byte_cnt  <= '0;
        finished  <= 1'b0;
        timeout   <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        case (state)
          S_TX: begin
            if (tx_bit_end) begin
              cnt      <= '0;
              tx_bits  <= tx_bits + 1'b1;
              tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_TURN: cnt <= turn_end ? '0 : cnt + 1'b1;
          S_RX_WAIT: begin
            if (start_seen) begin
              cnt <= '0;
            end else begin
              if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
              if (idle_exp) timeout <= 1'b1;
            end
          end
          S_RX_BYTE: begin
            if (byte_valid) begin
              wr_en    <= 1'b1;
              wr_addr  <= byte_cnt[ADDR_W-1:0];
              wr_data  <= byte_data;
              byte_cnt <= byte_cnt + 1'b1;
              if (stop_err) frame_err <= 1'b1;
            end
          end
          S_FILL: begin
            wr_en    <= 1'b1;
            wr_addr  <= byte_cnt[ADDR_W-1:0];
            wr_data  <= FILL_BYTE;
            byte_cnt <= byte_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      if (state_n == S_DONE && state != S_DONE) finished <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m16_uart_poll.sv
// tb/tb_m16_uart_poll.sv - scoreboard bench for m16_uart_poll (honours M16_RX_FILL_EN)
module tb_m16_uart_poll;

  localparam int CPB  = 17;
  localparam int PKT  = 18;
  localparam int AW   = 5;
  localparam int TURN = 34;
  localparam int TMO  = 4096;
`ifdef M16_RX_FILL_EN
  localparam int FILL = 1;
`else
  localparam int FILL = 0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk80MHz = 1'b0;
  logic          rst_n, poll_start, UART_RX;
  logic [7:0]    req_byte;
  logic          UART_TX, UART_dTX, UART_dRX, busy, wr_en, done, pkt_ok, timeout, frame_err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int  n_checks = 0;
  int  n_err    = 0;
  int  cyc      = 0;
  int  wr_total = 0;
  int  done_cnt = 0;
  int  t_done   = 0;
  int  wr_at_done = 0;
  logic d_ok, d_to, d_fe, d_busy;
  wr_t exp_q[$];
  wr_t mon_e;

  m16_uart_poll #(
    .CLKS_PER_BIT(CPB), .PKT_LEN(PKT), .ADDR_W(AW), .TURN_CLKS(TURN), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk80MHz (clk80MHz),
    .rst_n    (rst_n),
    .poll_start(poll_start),
    .req_byte (req_byte),
    .UART_RX  (UART_RX),
    .UART_TX  (UART_TX),
    .UART_dTX (UART_dTX),
    .UART_dRX (UART_dRX),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .pkt_ok   (pkt_ok),
    .timeout  (timeout),
    .frame_err(frame_err)
  );

  always #5 clk80MHz = ~clk80MHz;
  always @(posedge clk80MHz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk80MHz) begin
    if (wr_en) begin
      wr_total++;
      chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
    if (done) begin
      done_cnt++;
      t_done     = cyc;
      d_ok       = pkt_ok;
      d_to       = timeout;
      d_fe       = frame_err;
      d_busy     = busy;
      wr_at_done = wr_total;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    UART_RX = 1'b0;
    repeat (CPB) @(negedge clk80MHz);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (CPB) @(negedge clk80MHz);
    end
    UART_RX = stop;
    repeat (CPB) @(negedge clk80MHz);
    UART_RX = 1'b1;
    repeat (CPB) @(negedge clk80MHz);
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; busy && n < 200; n++) @(negedge clk80MHz);
    chk({name, ":idle_before"}, 32'(busy), 32'd0);
  endtask

  task automatic do_poll(input string name, input logic [7:0] cmd, input int nsend,
                         input int bad_idx, input bit glitch, input bit poke);
    logic [9:0] txb;
    logic       dtx_hi, dtx_lo, exp_to, exp_fe;
    int         n, base_done, base_wr, t_fall, exp_nwr, gap;
    wr_t        e;
    exp_to  = (nsend < PKT);
    exp_fe  = (bad_idx >= 0) && (bad_idx < nsend);
    exp_nwr = nsend + ((FILL != 0 && exp_to) ? PKT - nsend : 0);
    txb     = '0;
    wait_idle(name);
    base_done = done_cnt;
    base_wr   = wr_total;
    for (int i = 0; i < exp_nwr; i++) begin
      e.addr = AW'(i);
      e.data = (i < nsend) ? 8'(i * 10) : 8'h00;
      exp_q.push_back(e);
    end
    poll_start = 1'b1;
    req_byte   = cmd;
    @(negedge clk80MHz);
    poll_start = 1'b0;
    chk({name, ":tx_entry"}, 32'({busy, UART_dTX, UART_dRX, UART_TX}), 32'b1110);
    for (int c = 1; c <= 10 * CPB; c++) begin
      @(negedge clk80MHz);
      if (c % CPB == CPB / 2) txb[c / CPB] = UART_TX;
      if (c == 10 * CPB - 1) dtx_hi = UART_dTX;
      if (c == 10 * CPB) dtx_lo = UART_dTX;
    end
    chk({name, ":tx_frame"}, 32'(txb), 32'({1'b1, cmd, 1'b0}));
    chk({name, ":tx_len"}, 32'({dtx_hi, dtx_lo}), 32'b10);
    chk({name, ":turn_entry"}, 32'({UART_TX, UART_dRX}), 32'b11);
    for (n = 0; UART_dRX && n < 200; n++) @(negedge clk80MHz);
    chk({name, ":turn_len"}, 32'(n), 32'(TURN));
    t_fall = cyc;
    gap = 30 * CPB - TURN;
    if (glitch) begin
      UART_RX = 1'b0;
      repeat (2) @(negedge clk80MHz);
      UART_RX = 1'b1;
      repeat (40) @(negedge clk80MHz);
      chk({name, ":glitch_nowr"}, 32'(wr_total - base_wr), 32'd0);
      gap = gap - 42;
    end
    repeat (gap) @(negedge clk80MHz);
    for (int i = 0; i < nsend; i++) begin
      send_byte(8'(i * 10), (i == bad_idx) ? 1'b0 : 1'b1);
      if (poke && i == 3) begin
        poll_start = 1'b1;
        req_byte   = 8'hFF;
        @(negedge clk80MHz);
        poll_start = 1'b0;
        chk({name, ":poke_ignored"}, 32'({busy, UART_TX, UART_dTX}), 32'b110);
      end
    end
    for (n = 0; done_cnt == base_done && n < 8000; n++) @(negedge clk80MHz);
    @(negedge clk80MHz);
    chk({name, ":done_once"}, 32'(done_cnt - base_done), 32'd1);
    chk({name, ":status"}, 32'({d_ok, d_to, d_fe, d_busy}),
        32'({~exp_to & ~exp_fe, exp_to, exp_fe, 1'b0}));
    chk({name, ":nwr"}, 32'(wr_at_done - base_wr), 32'(exp_nwr));
    chk({name, ":q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, ":hold"}, 32'({pkt_ok, timeout, frame_err, busy}),
        32'({~exp_to & ~exp_fe, exp_to, exp_fe, 1'b0}));
    if (nsend == 0)
      chk({name, ":to_latency"}, 32'(t_done - t_fall), 32'(TMO + FILL * PKT));
  endtask

  initial begin
    int base_done;
    rst_n      = 1'b0;
    poll_start = 1'b0;
    req_byte   = 8'h00;
    UART_RX    = 1'b1;
    repeat (3) @(negedge clk80MHz);
    chk("rst_outs", 32'({UART_TX, UART_dTX, UART_dRX, busy, wr_en, done, pkt_ok, timeout, frame_err}),
        32'b100000000);
    chk("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk80MHz);

    do_poll("t1_full",   8'hA5, PKT, -1, 1'b0, 1'b0);
    do_poll("t2_silent", 8'h3C, 0,   -1, 1'b0, 1'b0);
    do_poll("t3_short",  8'h81, 10,  -1, 1'b0, 1'b0);
    do_poll("t4_ferr",   8'h5A, PKT, 5,  1'b0, 1'b0);
    do_poll("t5_glitch", 8'hC3, PKT, -1, 1'b1, 1'b0);
    do_poll("t6_poke",   8'h69, PKT, -1, 1'b0, 1'b1);

    wait_idle("t6_rst");
    base_done  = done_cnt;
    poll_start = 1'b1;
    req_byte   = 8'h5A;
    @(negedge clk80MHz);
    poll_start = 1'b0;
    repeat (4) @(negedge clk80MHz);
    chk("t6_rst:pre", 32'({UART_TX, UART_dTX, busy}), 32'b011);
    rst_n = 1'b0;
    #1;
    chk("t6_rst:async", 32'({UART_TX, UART_dTX, UART_dRX, busy}), 32'b1000);
    repeat (3) @(negedge clk80MHz);
    rst_n = 1'b1;
    repeat (300) @(negedge clk80MHz);
    chk("t6_rst:no_done", 32'(done_cnt - base_done), 32'd0);
    do_poll("t6_after", 8'h96, PKT, -1, 1'b0, 1'b0);

    chk("final_q", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
